// File: rtl/owt_rx_pkg.sv
// Shared types and constants for the OWT receive-side deframer.
package owt_rx_pkg;

    // Deframer states
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } owt_rx_st_e;

    // Default sync pattern, first received bit is the MSB
    localparam logic [3:0] OWT_RX_SYNC_PAT_DEF = 4'b1011;

    // Default payload width and its matching bit-counter width
    localparam int unsigned OWT_RX_DATA_W_DEF = 16;

    // Bit counter must be able to hold DATA_W itself
    function automatic int unsigned owt_rx_cnt_w(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

    localparam int unsigned OWT_RX_CNT_W_DEF = owt_rx_cnt_w(OWT_RX_DATA_W_DEF);

endpackage

// File: rtl/owt_rx_deframer_if.sv
// Bit-strobe input and frame-result output bundle of the OWT deframer.
interface owt_rx_deframer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              i_bit_vld;
    logic              i_bit_data;
    logic              o_frm_vld;
    logic [DATA_W-1:0] o_frm_data;
    logic              o_par_err;
    logic              o_to_err;
    logic              o_busy;

    // Detector / command-layer side: drives bits, consumes frames
    modport master (
        output i_bit_vld,
        output i_bit_data,
        input  o_frm_vld,
        input  o_frm_data,
        input  o_par_err,
        input  o_to_err,
        input  o_busy
    );

    // Deframer side
    modport slave (
        input  i_bit_vld,
        input  i_bit_data,
        output o_frm_vld,
        output o_frm_data,
        output o_par_err,
        output o_to_err,
        output o_busy
    );
endinterface

// File: rtl/owt_rx_to_timer.sv
// Saturating inter-bit timeout counter with threshold compare.
module owt_rx_to_timer #(
    parameter int unsigned     TO_W  = 12,
    parameter logic [TO_W-1:0] TO_TH = TO_W'(1000)
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);
    logic [TO_W-1:0] cnt;

    // Clear has priority; increment stops at all-ones instead of wrapping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_hit = (cnt == TO_TH);

endmodule

// File: rtl/owt_rx_deframer.sv
// OWT receive deframer: sync hunt, MSB-first payload capture, parity check
// and inter-bit timeout abort.
module owt_rx_deframer
    import owt_rx_pkg::*;
#(
    parameter int unsigned         DATA_W   = 16,
    parameter int unsigned         SYNC_LEN = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_LEN'(OWT_RX_SYNC_PAT_DEF),
    parameter bit                  PAR_ODD  = 1'b0,
    parameter int unsigned         TO_W     = 12,
    parameter logic [TO_W-1:0]     TO_TH    = TO_W'(1000)
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    owt_rx_deframer_if.slave bus
);
    localparam int unsigned CNT_W = owt_rx_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    owt_rx_st_e          state;
    logic [SYNC_LEN-1:0] sync_win;
    logic [SYNC_LEN-1:0] sync_win_nxt;
    logic [DATA_W-1:0]   payload;
    logic [CNT_W-1:0]    bit_cnt;
    logic                par_bad;
    logic                to_clr;
    logic                to_inc;
    logic                to_hit;

    // Next window value and parity verdict for the bit currently on the strobe
    always_comb begin
        sync_win_nxt = {sync_win[SYNC_LEN-2:0], bus.i_bit_data};
        par_bad      = (^payload) ^ bus.i_bit_data ^ PAR_ODD;
    end

    // Timer only runs while a frame is in flight and no strobe arrives
    always_comb begin
        to_clr = !i_en || (state == HUNT) || bus.i_bit_vld;
        to_inc = !to_clr;
    end

    owt_rx_to_timer #(
        .TO_W  (TO_W),
        .TO_TH (TO_TH)
    ) u_to_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (to_clr),
        .i_inc   (to_inc),
        .o_hit   (to_hit)
    );

    // Frame state machine and registered frame outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= HUNT;
            sync_win       <= '0;
            payload        <= '0;
            bit_cnt        <= '0;
            bus.o_frm_vld  <= 1'b0;
            bus.o_frm_data <= '0;
            bus.o_par_err  <= 1'b0;
            bus.o_to_err   <= 1'b0;
        end else begin
            bus.o_frm_vld <= 1'b0;
            bus.o_to_err  <= 1'b0;
            if (!i_en) begin
                state    <= HUNT;
                sync_win <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    HUNT: begin
                        if (bus.i_bit_vld) begin
                            if (sync_win_nxt == SYNC_PAT) begin
                                // Window is zeroed on lock so a later timeout
                                // cannot leave a stale pattern behind
                                state    <= DATA;
                                sync_win <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                sync_win <= sync_win_nxt;
                            end
                        end
                    end
                    DATA: begin
                        if (bus.i_bit_vld) begin
                            payload <= {payload[DATA_W-2:0], bus.i_bit_data};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= PARITY;
                            end
                        end else if (to_hit) begin
                            state        <= HUNT;
                            sync_win     <= '0;
                            bit_cnt      <= '0;
                            bus.o_to_err <= 1'b1;
                        end
                    end
                    PARITY: begin
                        if (bus.i_bit_vld) begin
                            state          <= HUNT;
                            sync_win       <= '0;
                            bit_cnt        <= '0;
                            bus.o_frm_vld  <= 1'b1;
                            bus.o_frm_data <= payload;
                            bus.o_par_err  <= par_bad;
                        end else if (to_hit) begin
                            state        <= HUNT;
                            sync_win     <= '0;
                            bit_cnt      <= '0;
                            bus.o_to_err <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        sync_win <= '0;
                        bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.o_busy = (state != HUNT);

endmodule

// File: tb/tb_owt_rx_deframer.sv
// Directed self-checking bench for owt_rx_deframer: defaults, odd parity
// and a short-timeout variant all fed the same bit stream.
module tb_owt_rx_deframer;

    logic clk;
    logic rst_n;
    logic en;
    logic bit_vld;
    logic bit_data;

    int n_checks;
    int n_errors;

    owt_rx_deframer_if #(.DATA_W(16)) bus0 ();
    owt_rx_deframer_if #(.DATA_W(16)) bus1 ();
    owt_rx_deframer_if #(.DATA_W(16)) bus2 ();

    assign bus0.i_bit_vld  = bit_vld;
    assign bus0.i_bit_data = bit_data;
    assign bus1.i_bit_vld  = bit_vld;
    assign bus1.i_bit_data = bit_data;
    assign bus2.i_bit_vld  = bit_vld;
    assign bus2.i_bit_data = bit_data;

    owt_rx_deframer dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .bus     (bus0)
    );

    owt_rx_deframer #(.PAR_ODD(1'b1)) dut_odd (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .bus     (bus1)
    );

    owt_rx_deframer #(.TO_TH(12'd20)) dut_to (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .bus     (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // All stimulus changes on the falling edge; outputs are read there too
    task automatic strobe(input logic b);
        bit_vld  = 1'b1;
        bit_data = b;
        @(negedge clk);
        bit_vld  = 1'b0;
        bit_data = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) strobe(v[i]);
    endtask

    task automatic send_frame(input logic [15:0] d, input logic p);
        send_bits(32'hB, 4);
        send_bits({16'h0, d}, 16);
        strobe(p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flush();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (bus0.o_frm_vld !== 1'b0) begin n_errors++; $display("FAIL reset_frm_vld: got %b expected 0", bus0.o_frm_vld); end
        n_checks++; if (bus0.o_frm_data !== 16'h0000) begin n_errors++; $display("FAIL reset_frm_data: got %h expected 0000", bus0.o_frm_data); end
        n_checks++; if (bus0.o_par_err !== 1'b0) begin n_errors++; $display("FAIL reset_par_err: got %b expected 0", bus0.o_par_err); end
        n_checks++; if (bus0.o_to_err !== 1'b0) begin n_errors++; $display("FAIL reset_to_err: got %b expected 0", bus0.o_to_err); end
        n_checks++; if (bus0.o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus0.o_busy); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_even_parity();
        send_bits(32'hB, 4);
        n_checks++; if (bus0.o_busy !== 1'b1) begin n_errors++; $display("FAIL even_busy_after_sync: got %b expected 1", bus0.o_busy); end
        send_bits(32'hA5C3, 16);
        n_checks++; if (bus0.o_frm_vld !== 1'b0 || bus0.o_busy !== 1'b1) begin n_errors++; $display("FAIL even_pre_parity: got vld=%b busy=%b expected vld=0 busy=1", bus0.o_frm_vld, bus0.o_busy); end
        strobe(1'b0);
        n_checks++; if (bus0.o_frm_vld !== 1'b1) begin n_errors++; $display("FAIL even_frm_vld: got %b expected 1", bus0.o_frm_vld); end
        n_checks++; if (bus0.o_frm_data !== 16'hA5C3) begin n_errors++; $display("FAIL even_frm_data: got %h expected a5c3", bus0.o_frm_data); end
        n_checks++; if (bus0.o_par_err !== 1'b0 || bus0.o_to_err !== 1'b0) begin n_errors++; $display("FAIL even_errs: got par=%b to=%b expected 0 0", bus0.o_par_err, bus0.o_to_err); end
        n_checks++; if (bus0.o_busy !== 1'b0) begin n_errors++; $display("FAIL even_busy_drop: got %b expected 0", bus0.o_busy); end
        idle(1);
        n_checks++; if (bus0.o_frm_vld !== 1'b0 || bus0.o_frm_data !== 16'hA5C3) begin n_errors++; $display("FAIL even_pulse_hold: got vld=%b data=%h expected 0 a5c3", bus0.o_frm_vld, bus0.o_frm_data); end
    endtask

    task automatic test_parity_err();
        send_frame(16'hA5C3, 1'b1);
        n_checks++; if (bus0.o_frm_vld !== 1'b1 || bus0.o_frm_data !== 16'hA5C3) begin n_errors++; $display("FAIL perr_frame: got vld=%b data=%h expected 1 a5c3", bus0.o_frm_vld, bus0.o_frm_data); end
        n_checks++; if (bus0.o_par_err !== 1'b1) begin n_errors++; $display("FAIL perr_even_flag: got %b expected 1", bus0.o_par_err); end
        n_checks++; if (bus1.o_frm_vld !== 1'b1 || bus1.o_frm_data !== 16'hA5C3) begin n_errors++; $display("FAIL perr_odd_frame: got vld=%b data=%h expected 1 a5c3", bus1.o_frm_vld, bus1.o_frm_data); end
        n_checks++; if (bus1.o_par_err !== 1'b0) begin n_errors++; $display("FAIL perr_odd_flag: got %b expected 0", bus1.o_par_err); end
        idle(1);
    endtask

    task automatic test_sliding_sync();
        send_bits(32'hD, 4);
        n_checks++; if (bus0.o_busy !== 1'b0) begin n_errors++; $display("FAIL slide_early_lock: got busy=%b expected 0", bus0.o_busy); end
        strobe(1'b1);
        n_checks++; if (bus0.o_busy !== 1'b1) begin n_errors++; $display("FAIL slide_lock_5th: got busy=%b expected 1", bus0.o_busy); end
        send_bits(32'h0001, 16);
        strobe(1'b1);
        n_checks++; if (bus0.o_frm_vld !== 1'b1 || bus0.o_frm_data !== 16'h0001 || bus0.o_par_err !== 1'b0) begin n_errors++; $display("FAIL slide_frame: got vld=%b data=%h par=%b expected 1 0001 0", bus0.o_frm_vld, bus0.o_frm_data, bus0.o_par_err); end
        idle(1);
        send_frame(16'hB0B0, 1'b0);
        n_checks++; if (bus0.o_frm_vld !== 1'b1 || bus0.o_frm_data !== 16'hB0B0 || bus0.o_par_err !== 1'b0) begin n_errors++; $display("FAIL no_false_resync: got vld=%b data=%h par=%b expected 1 b0b0 0", bus0.o_frm_vld, bus0.o_frm_data, bus0.o_par_err); end
        idle(1);
    endtask

    task automatic test_enable();
        logic seen;
        seen = 1'b0;
        send_bits(32'hB, 4);
        send_bits(32'hAB, 8);
        flush();
        n_checks++; if (bus0.o_busy !== 1'b0 || bus2.o_busy !== 1'b0) begin n_errors++; $display("FAIL en_abort_busy: got %b %b expected 0 0", bus0.o_busy, bus2.o_busy); end
        n_checks++; if (bus0.o_frm_data !== 16'hB0B0) begin n_errors++; $display("FAIL en_data_hold: got %h expected b0b0", bus0.o_frm_data); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus0.o_frm_vld || bus0.o_to_err || bus2.o_frm_vld || bus2.o_to_err) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL en_no_pulse: got %b expected 0", seen); end
        send_frame(16'h1234, 1'b1);
        n_checks++; if (bus0.o_frm_vld !== 1'b1 || bus0.o_frm_data !== 16'h1234 || bus0.o_par_err !== 1'b0) begin n_errors++; $display("FAIL en_new_frame: got vld=%b data=%h par=%b expected 1 1234 0", bus0.o_frm_vld, bus0.o_frm_data, bus0.o_par_err); end
        idle(1);
    endtask

    task automatic test_timeout();
        logic seen;
        seen = 1'b0;
        send_bits(32'hB, 4);
        send_bits(32'h16, 5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus2.o_to_err || bus2.o_frm_vld) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0 || bus2.o_busy !== 1'b1) begin n_errors++; $display("FAIL to_early: got seen=%b busy=%b expected 0 1", seen, bus2.o_busy); end
        idle(1);
        n_checks++; if (bus2.o_to_err !== 1'b1) begin n_errors++; $display("FAIL to_pulse_21: got %b expected 1", bus2.o_to_err); end
        n_checks++; if (bus2.o_frm_vld !== 1'b0 || bus2.o_busy !== 1'b0) begin n_errors++; $display("FAIL to_state: got vld=%b busy=%b expected 0 0", bus2.o_frm_vld, bus2.o_busy); end
        idle(1);
        n_checks++; if (bus2.o_to_err !== 1'b0) begin n_errors++; $display("FAIL to_one_cycle: got %b expected 0", bus2.o_to_err); end
        flush();
        idle(1);
    endtask

    task automatic test_timeout_boundary();
        logic seen;
        seen = 1'b0;
        send_bits(32'hB, 4);
        send_bits(32'h1234 >> 11, 5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus2.o_to_err) seen = 1'b1;
        end
        send_bits(32'h1234 & 32'h7FF, 11);
        if (bus2.o_to_err) seen = 1'b1;
        strobe(1'b1);
        n_checks++; if (seen !== 1'b0 || bus2.o_to_err !== 1'b0) begin n_errors++; $display("FAIL to_edge_no_err: got seen=%b to=%b expected 0 0", seen, bus2.o_to_err); end
        n_checks++; if (bus2.o_frm_vld !== 1'b1 || bus2.o_frm_data !== 16'h1234 || bus2.o_par_err !== 1'b0) begin n_errors++; $display("FAIL to_edge_frame: got vld=%b data=%h par=%b expected 1 1234 0", bus2.o_frm_vld, bus2.o_frm_data, bus2.o_par_err); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        send_frame(16'hFFFF, 1'b0);
        n_checks++; if (bus0.o_frm_vld !== 1'b1 || bus0.o_frm_data !== 16'hFFFF || bus0.o_par_err !== 1'b0) begin n_errors++; $display("FAIL b2b_first: got vld=%b data=%h par=%b expected 1 ffff 0", bus0.o_frm_vld, bus0.o_frm_data, bus0.o_par_err); end
        n_checks++; if (bus1.o_par_err !== 1'b1) begin n_errors++; $display("FAIL b2b_first_odd: got %b expected 1", bus1.o_par_err); end
        send_frame(16'h0000, 1'b0);
        n_checks++; if (bus0.o_frm_vld !== 1'b1 || bus0.o_frm_data !== 16'h0000 || bus0.o_par_err !== 1'b0) begin n_errors++; $display("FAIL b2b_second: got vld=%b data=%h par=%b expected 1 0000 0", bus0.o_frm_vld, bus0.o_frm_data, bus0.o_par_err); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        send_frame(16'h5A5A, 1'b0);
        idle(1);
        n_checks++; if (bus0.o_frm_data !== 16'h5A5A) begin n_errors++; $display("FAIL rstmid_pre_data: got %h expected 5a5a", bus0.o_frm_data); end
        send_bits(32'hB, 4);
        send_bits(32'hF, 4);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus0.o_frm_data !== 16'h0000 || bus0.o_busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_async: got data=%h busy=%b expected 0000 0", bus0.o_frm_data, bus0.o_busy); end
        n_checks++; if (bus0.o_frm_vld !== 1'b0 || bus0.o_par_err !== 1'b0 || bus0.o_to_err !== 1'b0) begin n_errors++; $display("FAIL rstmid_flags: got %b %b %b expected 0 0 0", bus0.o_frm_vld, bus0.o_par_err, bus0.o_to_err); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_frame(16'h00FF, 1'b0);
        n_checks++; if (bus0.o_frm_vld !== 1'b1 || bus0.o_frm_data !== 16'h00FF) begin n_errors++; $display("FAIL rstmid_recover: got vld=%b data=%h expected 1 00ff", bus0.o_frm_vld, bus0.o_frm_data); end
        idle(1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        bit_vld  = 1'b0;
        bit_data = 1'b0;
        test_reset();
        test_even_parity();
        test_parity_err();
        test_sliding_sync();
        test_enable();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
